// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Optional unsigned-operand support is enabled by BOOTH_MULT_UNSIGNED_SEL_EN.
package booth_mult_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_digit_t;

   // {y[2k+1], y[2k], y[2k-1]} -> signed digit in {-2,-1,0,+1,+2}
   function automatic booth_digit_t booth_decode(input logic [2:0] win);
      booth_digit_t d;
      d = '0;
      case (win)
         3'b001, 3'b010: d.one = 1'b1;
         3'b011:         d.two = 1'b1;
         3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
         3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
         default:        d = '0;
      endcase
      return d;
   endfunction

   function automatic int booth_cycles(input int width, input int dpc);
      return width / (2 * dpc);
   endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// One radix-4 Booth digit: 3-bit window and pre-shifted multiplicand in,
// full-width two's-complement partial product out.
module booth_r4_digit_enc
   import booth_mult_pkg::*;
#(
   parameter int PW = 32
) (
   input  logic [2:0]    win_i,
   input  logic [PW-1:0] x_i,
   output logic [PW-1:0] pp_o
);

   booth_digit_t dig;
   logic [PW-1:0] mag;

   assign dig = booth_decode(win_i);

   always_comb begin
      mag = '0;
      if (dig.one)
         mag = x_i;
      else if (dig.two)
         mag = {x_i[PW-2:0], 1'b0};
      pp_o = dig.neg ? (~mag + 1'b1) : mag;
   end

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready both sides.
// Define BOOTH_MULT_UNSIGNED_SEL_EN to add unsigned_i (per-op unsigned operands).
module booth_radix4_seq_mult
   import booth_mult_pkg::*;
#(
   parameter int WIDTH            = 16,
   parameter int DIGITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   x_i,
   input  logic [WIDTH-1:0]   y_i,
`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
   input  logic               unsigned_i,
`endif
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] out_o
);

   localparam int PW  = 2 * WIDTH;
   localparam int DPC = DIGITS_PER_CYCLE;
   localparam int N   = booth_cycles(WIDTH, DPC);
   localparam int CW  = $clog2(N + 1) + 1;

   state_e              state_q, state_d;
   logic [PW-1:0]       mcand_q, mcand_d;
   logic [WIDTH:0]      ysh_q, ysh_d;
   logic                uns_q, uns_d;
   logic [PW-1:0]       acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PW-1:0]       out_q, out_d;
   logic                uns_in;
   logic                fill;
   logic [CW-1:0]       last_cnt;
   logic [DPC-1:0][PW-1:0] pp;
   logic [PW-1:0]       psum;

`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
   assign uns_in = unsigned_i;
`else
   assign uns_in = 1'b0;
`endif

   // Unsigned ops shift zeros in from the top, which yields the extra digit {0,0,y[W-1]}
   assign fill     = uns_q ? 1'b0 : ysh_q[WIDTH];
   assign last_cnt = uns_q ? CW'(N) : CW'(N - 1);

   for (genvar d = 0; d < DPC; d++) begin : g_dig
      logic [PW-1:0] x_sh;
      assign x_sh = mcand_q << (2 * d);
      booth_r4_digit_enc #(.PW(PW)) u_enc (
         .win_i (ysh_q[2*d+2 -: 3]),
         .x_i   (x_sh),
         .pp_o  (pp[d])
      );
   end

   always_comb begin
      psum = '0;
      for (int i = 0; i < DPC; i++)
         psum = psum + pp[i];
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign out_o       = out_q;

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      ysh_d   = ysh_q;
      uns_d   = uns_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      case (state_q)
         IDLE: if (in_valid_i) begin
            mcand_d = uns_in ? {{WIDTH{1'b0}}, x_i} : {{WIDTH{x_i[WIDTH-1]}}, x_i};
            ysh_d   = {y_i, 1'b0};
            uns_d   = uns_in;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            acc_d   = acc_q + psum;
            mcand_d = mcand_q << (2 * DPC);
            ysh_d   = {{(2*DPC){fill}}, ysh_q[WIDTH:2*DPC]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == last_cnt) begin
               out_d   = acc_d;
               state_d = DONE;
            end
         end
         DONE: if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= '0;
         ysh_q   <= '0;
         uns_q   <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         ysh_q   <= ysh_d;
         uns_q   <= uns_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Self-checking bench: DPC=1 main DUT plus DPC=2 and DPC=4 copies on shared inputs.
module tb_booth_radix4_seq_mult;

   localparam int W  = 16;
   localparam int N1 = 8;
   localparam int N2 = 4;
   localparam int N4 = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid_i, out_ready_i;
   logic [W-1:0]   x_i, y_i;
   logic           in_ready_o, in_ready2, in_ready4;
   logic           out_valid_o, out_valid2, out_valid4;
   logic [2*W-1:0] out_o, out2, out4;
`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
   logic           unsigned_i;
`endif

   always #5 clk = ~clk;

   booth_radix4_seq_mult #(.WIDTH(W), .DIGITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .x_i(x_i), .y_i(y_i),
`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
      .unsigned_i(unsigned_i),
`endif
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_o(out_o));

   booth_radix4_seq_mult #(.WIDTH(W), .DIGITS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready2),
      .x_i(x_i), .y_i(y_i),
`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
      .unsigned_i(unsigned_i),
`endif
      .out_valid_o(out_valid2), .out_ready_i(out_ready_i), .out_o(out2));

   booth_radix4_seq_mult #(.WIDTH(W), .DIGITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready4),
      .x_i(x_i), .y_i(y_i),
`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
      .unsigned_i(unsigned_i),
`endif
      .out_valid_o(out_valid4), .out_ready_i(out_ready_i), .out_o(out4));

   typedef struct {
      logic [W-1:0]   x;
      logic [W-1:0]   y;
      logic [2*W-1:0] p;
   } vec_t;

   int             pass_cnt  = 0;
   int             total_cnt = 0;
   logic [2*W-1:0] exp_q[$];
   vec_t           tbl[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      return 32'(sa * sb);
   endfunction

   task automatic wait_ready(input string nm);
      int w;
      w = 0;
      while (!(in_ready_o && in_ready2 && in_ready4) && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk({nm, "_ready"}, 64'(in_ready_o), 64'd1);
   endtask

   // Issue one op; hold > 0 stalls the consumer for that many cycles while junk in_valid is offered
   task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [2*W-1:0] ev,
                         input logic uns, input int hold, input string nm);
      int edges, lat2, lat4;
      logic [2*W-1:0] r2, r4, held;
      logic stable;
      wait_ready(nm);
      x_i = xv; y_i = yv; in_valid_i = 1'b1;
      out_ready_i = (hold == 0);
`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
      unsigned_i = uns;
`endif
      exp_q.push_back(ev);
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      x_i = W'($urandom); y_i = W'($urandom);
`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
      unsigned_i = ~uns;
`endif
      edges = 1; lat2 = 0; lat4 = 0; r2 = '0; r4 = '0;
      @(negedge clk);
      while (!out_valid_o && edges < 40) begin
         if (out_valid2 && lat2 == 0) begin lat2 = edges; r2 = out2; end
         if (out_valid4 && lat4 == 0) begin lat4 = edges; r4 = out4; end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk({nm, "_valid"}, 64'(out_valid_o), 64'd1);
      chk({nm, "_lat1"}, 64'(edges), 64'(uns ? N1 + 2 : N1 + 1));
      chk({nm, "_lat2"}, 64'(lat2), 64'(uns ? N2 + 2 : N2 + 1));
      chk({nm, "_lat4"}, 64'(lat4), 64'(uns ? N4 + 2 : N4 + 1));
      chk({nm, "_prod"}, 64'(out_o), 64'(exp_q.pop_front()));
      chk({nm, "_prod2"}, 64'(r2), 64'(ev));
      chk({nm, "_prod4"}, 64'(r4), 64'(ev));
      if (hold > 0) begin
         held = out_o;
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            in_valid_i = 1'b1;
            x_i = W'($urandom); y_i = W'($urandom);
            @(negedge clk);
            if (!out_valid_o || out_o !== held || in_ready_o) stable = 1'b0;
         end
         in_valid_i = 1'b0;
         chk({nm, "_hold"}, 64'(stable), 64'd1);
         out_ready_i = 1'b1;
      end
      @(posedge clk);
      #1;
      chk({nm, "_idle"}, 64'({out_valid_o, in_ready_o}), 64'b01);
      chk({nm, "_keep"}, 64'(out_o), 64'(ev));
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      x_i = '0; y_i = '0;
`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
      unsigned_i = 1'b0;
`endif
      tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F};
      tbl[1] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
      tbl[2] = '{16'h8000, 16'h8000, 32'h40000000};
      tbl[3] = '{16'h7FFF, 16'h8000, 32'hC0008000};
      tbl[4] = '{16'h0007, 16'hFFFE, 32'hFFFFFFF2};
      tbl[5] = '{16'h0000, 16'h1234, 32'h00000000};
      tbl[6] = '{16'h0001, 16'h8000, 32'hFFFF8000};
      tbl[7] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
      tbl[8] = '{16'hFFFF, 16'h0002, 32'hFFFFFFFE};
      for (int i = 9; i < 16; i++) begin
         tbl[i].x = W'($urandom);
         tbl[i].y = W'($urandom);
         tbl[i].p = smul(tbl[i].x, tbl[i].y);
      end

      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(in_ready_o), 64'd1);
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_out", 64'(out_o), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++)
         run_op(tbl[i].x, tbl[i].y, tbl[i].p, 1'b0, 0, $sformatf("v%0d", i));

      run_op(16'h0123, 16'hFF00, 32'hFFFEDD00, 1'b0, 10, "bp");

      // Reset asserted during the fourth BUSY cycle discards the op
      wait_ready("rs");
      x_i = 16'h1234; y_i = 16'h0567; in_valid_i = 1'b1;
      @(posedge clk);
      #1 in_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rs_ready", 64'(in_ready_o), 64'd1);
      chk("rs_valid", 64'(out_valid_o), 64'd0);
      chk("rs_out", 64'(out_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid_o || out_valid2 || out_valid4) seen++;
      end
      chk("rs_noemit", 64'(seen), 64'd0);
      run_op(16'h0007, 16'hFFFE, 32'hFFFFFFF2, 1'b0, 0, "rs_next");

`ifdef BOOTH_MULT_UNSIGNED_SEL_EN
      run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 0, "uns1");
      run_op(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 0, "uns0");
      run_op(16'h8000, 16'hC000, 32'h60000000, 1'b1, 0, "uns2");
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
